// File: rtl/cod_pkg.sv
// Shared types and widths for the character-entry encoder.
package cod_pkg;

    localparam int unsigned CODE_W = 5;

    typedef enum logic {
        EDIT   = 1'b0,
        LOCKED = 1'b1
    } cod_state_t;

endpackage

// File: rtl/cod_entrada_caracter_if.sv
// Button/display bundle between the board buttons and the display top.
// master = button side (drives btn_*), slave = encoder side (drives code outputs).
interface cod_entrada_caracter_if;

    logic btn_up;
    logic btn_down;
    logic btn_ok;
    logic A;
    logic B;
    logic C;
    logic D;
    logic E;
    logic code_valid;
    logic locked;

    modport master (
        output btn_up, btn_down, btn_ok,
        input  A, B, C, D, E, code_valid, locked
    );

    modport slave (
        input  btn_up, btn_down, btn_ok,
        output A, B, C, D, E, code_valid, locked
    );

endinterface

// File: rtl/cod_debounce.sv
// Per-button 2-flop synchronizer, debounce counter and registered press pulse.
module cod_debounce #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Rising edge of the debounced level only; releases are silent.
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cod_entrada_caracter.sv
// Character-entry encoder: debounced up/down/ok buttons step and lock a 5-bit code A..E.
// Optional auto-repeat while up/down is held: define COD_AUTO_REPEAT_EN.
module cod_entrada_caracter
    import cod_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 50000,
    parameter int unsigned MAX_CODE      = 31,
    parameter int unsigned REPEAT_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_ok,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic code_valid,
    output logic locked
);

    localparam logic [CODE_W-1:0] MAX_SEL = CODE_W'(MAX_CODE);

    logic up_lvl, up_p, dn_lvl, dn_p, ok_lvl, ok_p;

    cod_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst), .raw(btn_up), .level(up_lvl), .press(up_p)
    );
    cod_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk(clk), .rst(rst), .raw(btn_down), .level(dn_lvl), .press(dn_p)
    );
    cod_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
        .clk(clk), .rst(rst), .raw(btn_ok), .level(ok_lvl), .press(ok_p)
    );

    cod_state_t        state_q, state_d;
    logic [CODE_W-1:0] sel_q, sel_d;
    logic              code_valid_q, code_valid_d;
    logic              locked_q, locked_d;
    logic              step_up, step_dn;
    logic              ok_lvl_unused;

    assign ok_lvl_unused = ok_lvl;

`ifdef COD_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_fire;

    // Counter restarts on each press pulse so repeats are spaced from the first step.
    always_comb begin
        rpt_cnt_d = '0;
        rpt_fire  = 1'b0;
        if (state_q == EDIT && !ok_p && (up_lvl ^ dn_lvl) && !up_p && !dn_p) begin
            if (rpt_cnt_q == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
        step_up = up_p | (rpt_fire & up_lvl);
        step_dn = dn_p | (rpt_fire & dn_lvl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    always_comb begin
        step_up = up_p;
        step_dn = dn_p;
    end
`endif

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        code_valid_d = 1'b0;
        case (state_q)
            EDIT: begin
                if (ok_p) begin
                    state_d      = LOCKED;
                    code_valid_d = 1'b1;
                end else if (step_up && !step_dn) begin
                    sel_d = (sel_q == MAX_SEL) ? '0 : sel_q + CODE_W'(1);
                end else if (step_dn && !step_up) begin
                    sel_d = (sel_q == '0) ? MAX_SEL : sel_q - CODE_W'(1);
                end
            end
            LOCKED: begin
                if (ok_p) begin
                    state_d = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EDIT;
            sel_q        <= '0;
            code_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            code_valid_q <= code_valid_d;
            locked_q     <= locked_d;
        end
    end

    assign {A, B, C, D, E} = sel_q;
    assign code_valid      = code_valid_q;
    assign locked          = locked_q;

endmodule

// File: doc/cod_entrada_caracter.md
# cod_entrada_caracter

Character-entry encoder for the display datapath: turns three raw pushbuttons (up, down, ok) into the 5-bit code `A..E` that the character/hex/LED display decoders consume. It synchronizes and debounces each button, steps a selection register with wrap-around, and locks the selection on confirm with a one-cycle valid strobe. It sits between the board buttons and the existing display top, driving the display top's `A..E` inputs directly.

## Interface
- `DEB_CYCLES`, default 50000: consecutive stable cycles required to accept a button level (1 ms at 50 MHz); must be ≥ 2.
- `MAX_CODE`, default 31: highest selectable code; range 1..31.
- `REPEAT_CYCLES`, default 12500000: auto-repeat period; used only with `COD_AUTO_REPEAT_EN`.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_up`  in  1  raw, asynchronous, active-high button.
- `btn_down`  in  1  raw, asynchronous, active-high button.
- `btn_ok`  in  1  raw, asynchronous, active-high button.
- `A`, `B`, `C`, `D`, `E`  out  1 each  current selection; `A` is the MSB, `E` the LSB.
- `code_valid`  out  1  one-cycle pulse when a selection is committed.
- `locked`  out  1  high while the selection is committed.

## Operation
- Per button: 2-flop synchronizer, then debounce. The counter increments while the synchronized level differs from the debounced level and clears otherwise. When the counter reaches `DEB_CYCLES-1` with the level still differing, the debounced level updates and the counter clears. A registered press pulse fires on the debounced rising edge only; releases generate nothing.
- Selection register `sel[4:0]` drives `A..E` continuously, in both states.
- FSM states:
  - `EDIT`
    - up pulse: `sel = (sel == MAX_CODE) ? 0 : sel+1`.
    - down pulse: `sel = (sel == 0) ? MAX_CODE : sel-1`.
    - ok pulse: go to `LOCKED` and assert `code_valid` for exactly one cycle.
  - `LOCKED`
    - `locked` = 1.
    - up and down pulses are ignored.
    - ok pulse: return to `EDIT`; no `code_valid`.
- Simultaneous pulses in the same cycle:
  - ok has priority over up/down; `sel` does not change in that cycle.
  - up together with down and no ok: `sel` is unchanged.
- Reset values:
  - `sel` = 0, so `A..E` = 0.
  - State `EDIT`, `code_valid` = 0, `locked` = 0.
  - All synchronizer flops, debounced levels and counters = 0.
- Reset mid-operation (including mid-debounce or in `LOCKED`): all of the above values on the next edge. A button still held through reset release is seen as a new press once debounced.

## Timing
- Raw level change held stable, first sampled at edge t:
  - debounced level updates at edge t+1+`DEB_CYCLES`;
  - press pulse is high at edge t+2+`DEB_CYCLES`;
  - `sel`, `code_valid` and `locked` update at edge t+3+`DEB_CYCLES`.
- A raw glitch shorter than `DEB_CYCLES` synchronized cycles produces no pulse and no output change.
- `code_valid` is never high for two consecutive cycles. One physical press produces at most one step (without auto-repeat).
- All outputs are registered; there are no combinational paths from the buttons.

## Configuration
- `COD_AUTO_REPEAT_EN` defined:
  - In `EDIT`, while debounced up (or down) stays high, a repeat counter generates an additional step every `REPEAT_CYCLES` cycles after the initial press pulse.
  - The counter clears on release, on entering `LOCKED`, or when both buttons are held.
  - Wrap-around rules apply to repeat steps.
- Not defined:
  - Exactly one step per press.
  - The repeat counter and the `REPEAT_CYCLES` logic are absent.

## Structure
- Shared package `cod_pkg`: `CODE_W = 5` and the state enum `cod_state_t {EDIT, LOCKED}`.
- Sub-module `cod_debounce`, parameterized by `DEB_CYCLES`, instantiated three times. Ports: `clk`, `rst`, `raw`, `level`, `press`.
- The FSM, selection register and optional repeat logic live in the top.

## Test plan
Bench uses `DEB_CYCLES = 4`, `MAX_CODE = 31`, `REPEAT_CYCLES = 16`.
- Reset and press timing: hold `rst` for 2 cycles → `A..E` = 0, `code_valid` = 0, `locked` = 0. Then hold `btn_up` for 10 cycles → `sel` = 1 exactly 7 edges after the first sampling edge; no further change while held (macro off).
- Glitch rejection: a `btn_up` pulse of 3 cycles → `sel` unchanged. A 0-1-0-1 chatter of 1-cycle width → no step.
- Wrap-around: 31 up presses from 0 → `sel` = 31. One more up → 0. One down from 0 → 31.
- Commit and lock: set `sel` = 5, press ok → `code_valid` high for exactly 1 cycle, `locked` = 1, `A..E` = 00101. Up and down presses → still 5. Ok again → `locked` = 0, no `code_valid`.
- Simultaneous events: up+down debounced on the same cycle → no change. Up+ok on the same cycle at `sel` = 7 → `locked` = 1, `sel` = 7. Reset asserted in `LOCKED` → `sel` = 0, `EDIT`.
- Auto-repeat (macro on): hold up for 60 cycles after debounce → `sel` = 0→1 on the press, then +1 every 16 cycles (1,2,3,4). Release → stops.
